led_blink_sequencer: RTL

LED_BLINK_SEQUENCER -- requirements
Module: led_blink_sequencer

---
 rtl/led_blink_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/led_blink_sequencer.sv
// LED blink sequencer: debounced button cycles IDLE/RATE/SYNC/CHASE.
// CHASE mode is compiled only when LED_SEQ_CHASE_EN is defined.
module led_blink_sequencer #(
  parameter int g_DEBOUNCE_LIMIT = 250000,
  parameter int g_COUNT_10HZ     = 1250000,
  parameter int g_COUNT_5HZ      = 2500000,
  parameter int g_COUNT_2HZ      = 6250000,
  parameter int g_COUNT_1HZ      = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int DW  = $clog2(g_DEBOUNCE_LIMIT);
  localparam int W10 = $clog2(g_COUNT_10HZ);
  localparam int W5  = $clog2(g_COUNT_5HZ);
  localparam int W2  = $clog2(g_COUNT_2HZ);
  localparam int W1  = $clog2(g_COUNT_1HZ);

  localparam logic [DW-1:0]  DB_MAX = DW'(g_DEBOUNCE_LIMIT - 1);
  localparam logic [W10-1:0] M10    = W10'(g_COUNT_10HZ - 1);
  localparam logic [W5-1:0]  M5     = W5'(g_COUNT_5HZ - 1);
  localparam logic [W2-1:0]  M2     = W2'(g_COUNT_2HZ - 1);
  localparam logic [W1-1:0]  M1     = W1'(g_COUNT_1HZ - 1);

`ifdef LED_SEQ_CHASE_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RATE  = 2'd1,
    SYNC  = 2'd2,
    CHASE = 2'd3
  } mode_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RATE = 2'd1,
    SYNC = 2'd2
  } mode_t;
`endif

  logic           sw_m;
  logic           sw_s;
  logic           sw_d;
  logic           sw_q;
  logic [DW-1:0]  db_cnt;
  logic [W10-1:0] c10;
  logic [W5-1:0]  c5;
  logic [W2-1:0]  c2;
  logic [W1-1:0]  c1;
  logic [3:0]     led;
  mode_t          mode;
  mode_t          nxt;
  logic [3:0]     entry;
  logic           rel;

  // release = stable level fell on the previous edge
  assign rel = sw_q & ~sw_d;

  always_comb begin
    nxt   = IDLE;
    entry = 4'b0000;
    case (mode)
      IDLE: nxt = RATE;
      RATE: nxt = SYNC;
`ifdef LED_SEQ_CHASE_EN
      SYNC: begin
        nxt   = CHASE;
        entry = 4'b0001;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sw_m   <= 1'b0;
      sw_s   <= 1'b0;
      sw_d   <= 1'b0;
      sw_q   <= 1'b0;
      db_cnt <= '0;
      c10    <= '0;
      c5     <= '0;
      c2     <= '0;
      c1     <= '0;
      led    <= 4'b0000;
      mode   <= IDLE;
    end else begin
      sw_m <= i_Switch;
      sw_s <= sw_m;
      sw_q <= sw_d;

      if (sw_s == sw_d) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        sw_d   <= sw_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (rel) begin
        mode <= nxt;
        c10  <= '0;
        c5   <= '0;
        c2   <= '0;
        c1   <= '0;
        led  <= entry;
      end else begin
        case (mode)
          RATE: begin
            if (c10 == M10) begin
              c10    <= '0;
              led[0] <= ~led[0];
            end else c10 <= c10 + 1'b1;
            if (c5 == M5) begin
              c5     <= '0;
              led[1] <= ~led[1];
            end else c5 <= c5 + 1'b1;
            if (c2 == M2) begin
              c2     <= '0;
              led[2] <= ~led[2];
            end else c2 <= c2 + 1'b1;
            if (c1 == M1) begin
              c1     <= '0;
              led[3] <= ~led[3];
            end else c1 <= c1 + 1'b1;
          end
          SYNC: begin
            if (c5 == M5) begin
              c5  <= '0;
              led <= ~led;
            end else c5 <= c5 + 1'b1;
          end
`ifdef LED_SEQ_CHASE_EN
          CHASE: begin
            if (c10 == M10) begin
              c10 <= '0;
              led <= {led[2:0], led[3]};
            end else c10 <= c10 + 1'b1;
          end
`endif
          default: begin
            c10 <= '0;
            c5  <= '0;
            c2  <= '0;
            c1  <= '0;
            led <= 4'b0000;
          end
        endcase
      end
    end
  end

  assign o_LED_1 = led[0];
  assign o_LED_2 = led[1];
  assign o_LED_3 = led[2];
  assign o_LED_4 = led[3];
  assign o_Mode  = mode;

endmodule
